accu_store_unit: RTL and testbench
==================================

Name: accu_store_unit

Overview:
- Write-back path for the 8-bit accumulator.
- On a store command it copies the current ACCUMULATOR value to one of three destinations: the output port latch, the register file, or data RAM.
- RAM stores use a request/acknowledge handshake with wait states.
- Sits beside the accumulator in each PLC core. The core sequencer stalls on STORE_Busy.

Parameters:
- DATA_W, 8, accumulator/data width.
- ADDR_W, 8, RAM address width.
- REG_ADDR_W, 3, register file address width (low bits of STORE_Addr).
- TIMEOUT_CYCLES, 16, max cycles RAM_Req may wait for RAM_Ack (used only with the optional feature).

Ports:
- CLK  in  1  core clock, all logic on rising edge.
- CPU_Reset  in  1  synchronous, active-high reset.
- STORE_Start  in  1  store command strobe, sampled only in IDLE.
- STORE_OPCode  in  2  destination: 00 output port, 01 register, 10 RAM, 11 illegal.
- STORE_Addr  in  ADDR_W  destination address (register uses low REG_ADDR_W bits).
- ACCUMULATOR  in  DATA_W  value to store.
- STORE_Busy  out  1  high whenever state != IDLE.
- STORE_Done  out  1  one-cycle completion pulse.
- STORE_Error  out  1  last store failed (illegal opcode or timeout).
- OUT_Port  out  DATA_W  latched output port value.
- OUT_Strobe  out  1  one-cycle pulse when OUT_Port is updated.
- REG_WE  out  1  one-cycle register write enable.
- REG_Addr  out  REG_ADDR_W  register write address.
- REG_WData  out  DATA_W  register write data.
- RAM_Req  out  1  RAM write request, held until acknowledged.
- RAM_WE  out  1  equals RAM_Req (write-only master).
- RAM_Addr  out  ADDR_W  RAM address, stable while RAM_Req = 1.
- RAM_WData  out  DATA_W  RAM data, stable while RAM_Req = 1.
- RAM_Ack  in  1  RAM write accepted, sampled only while RAM_Req = 1.

Interface note: one clock, CLK. CPU_Reset is synchronous and active-high. All outputs are registered.

Behaviour:
- States: IDLE, RAM_WAIT, DONE.
- Reset (sampled at a CLK edge): state goes to IDLE, every output goes to 0 (including OUT_Port and STORE_Error). Any pending RAM request is dropped with no Done pulse. Reset overrides all other events in the same cycle.
- IDLE with STORE_Start = 1 at edge E0: ACCUMULATOR, STORE_Addr and STORE_OPCode are captured and STORE_Error is cleared. Then, by opcode:
  - 00: OUT_Port <= data; OUT_Strobe = 1 and STORE_Done = 1 in the cycle after E0; state goes to DONE.
  - 01: REG_WE = 1 with REG_Addr/REG_WData for one cycle after E0; STORE_Done = 1 in the same cycle; state goes to DONE.
  - 10: RAM_Req = RAM_WE = 1, with RAM_Addr/RAM_WData from the captured values; state goes to RAM_WAIT.
  - 11: no destination is written; STORE_Error <= 1 and STORE_Done = 1 in the cycle after E0; state goes to DONE.
- DONE: lasts one cycle, then IDLE. Busy stays high during DONE, so back-to-back stores are spaced 2 cycles apart (port/register).
- RAM_WAIT:
  - At an edge with RAM_Ack = 1: RAM_Req/RAM_WE drop, STORE_Done pulses in the next cycle, state goes to DONE.
  - With Ack already high in the first Req cycle, Done appears 2 cycles after E0.
  - RAM_Addr/RAM_WData hold their values until Ack.
- RAM_Ack while RAM_Req = 0 is ignored.
- STORE_Start when not in IDLE is ignored; no queuing.
- ACCUMULATOR changes after capture do not affect the stored value.
- OUT_Port holds its last value indefinitely. Pulse outputs (OUT_Strobe, REG_WE, STORE_Done) are exactly one cycle wide.
- STORE_Error is sticky until the next accepted STORE_Start or reset.
- Without the optional feature, RAM_WAIT waits for Ack forever.

Optional Feature:
- Macro: ACCU_STORE_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES + 1) counts cycles spent in RAM_WAIT, starting at 1 in the first Req cycle.
  - If the counter reaches TIMEOUT_CYCLES without Ack, the request is aborted: RAM_Req drops, STORE_Error <= 1, STORE_Done pulses, state goes to DONE.
  - If Ack arrives on the same edge as the timeout, Ack wins: the store succeeds and no error is flagged.
- When undefined: no counter logic, and STORE_Error is set only by opcode 11.

Test Plan:
- Port store: ACCUMULATOR = 8'hA5, opcode 00, Start for 1 cycle -> next cycle OUT_Port = A5, OUT_Strobe = 1, STORE_Done = 1; Busy high for 2 cycles; OUT_Port still A5 ten cycles later.
- Register store: opcode 01, Addr = 8'h0D, ACCUMULATOR = 8'h3C -> one cycle with REG_WE = 1, REG_Addr = 3'd5, REG_WData = 3C; then change ACCUMULATOR to 00 -> no further register write.
- RAM store with 3 wait states: opcode 10, Addr = 8'h40, data 8'h77, RAM_Ack asserted in the 4th Req cycle -> RAM_Req high exactly 4 cycles with Addr/Data stable; Done 1 cycle later; a Start issued during RAM_WAIT is ignored.
- Illegal opcode 11 -> no OUT_Strobe/REG_WE/RAM_Req; STORE_Error = 1 with Done. A following valid store clears STORE_Error at its start edge.
- Reset mid-op: CPU_Reset in the 2nd cycle of RAM_WAIT -> next edge RAM_Req = 0, Busy = 0, OUT_Port = 0, no Done pulse; a later Ack is ignored.
- With ACCU_STORE_TIMEOUT_EN defined and TIMEOUT_CYCLES = 4, RAM_Ack held low -> RAM_Req drops after 4 cycles, STORE_Error = 1, Done pulses. A repeat run with Ack on the 4th cycle -> success, STORE_Error = 0.

Source files
------------

// File: rtl/accu_store_unit.sv
// Accumulator write-back unit: copies ACCUMULATOR to the output port, register file or data RAM.
// Optional RAM acknowledge timeout is enabled by defining ACCU_STORE_TIMEOUT_EN.
module accu_store_unit #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int REG_ADDR_W     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  CPU_Reset,
    input  logic                  STORE_Start,
    input  logic [1:0]            STORE_OPCode,
    input  logic [ADDR_W-1:0]     STORE_Addr,
    input  logic [DATA_W-1:0]     ACCUMULATOR,
    output logic                  STORE_Busy,
    output logic                  STORE_Done,
    output logic                  STORE_Error,
    output logic [DATA_W-1:0]     OUT_Port,
    output logic                  OUT_Strobe,
    output logic                  REG_WE,
    output logic [REG_ADDR_W-1:0] REG_Addr,
    output logic [DATA_W-1:0]     REG_WData,
    output logic                  RAM_Req,
    output logic                  RAM_WE,
    output logic [ADDR_W-1:0]     RAM_Addr,
    output logic [DATA_W-1:0]     RAM_WData,
    input  logic                  RAM_Ack
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RAM_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    logic [1:0]            state_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  error_reg;
    logic [DATA_W-1:0]     out_port_reg;
    logic                  out_strobe_reg;
    logic                  reg_we_reg;
    logic [REG_ADDR_W-1:0] reg_addr_reg;
    logic [DATA_W-1:0]     reg_wdata_reg;
    logic                  ram_req_reg;
    logic [ADDR_W-1:0]     ram_addr_reg;
    logic [DATA_W-1:0]     ram_wdata_reg;

`ifdef ACCU_STORE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
`else
    logic timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge CLK) begin
        if (CPU_Reset) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            out_port_reg   <= '0;
            out_strobe_reg <= 1'b0;
            reg_we_reg     <= 1'b0;
            reg_addr_reg   <= '0;
            reg_wdata_reg  <= '0;
            ram_req_reg    <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
`ifdef ACCU_STORE_TIMEOUT_EN
            wait_cnt_reg   <= '0;
`endif
        end else begin
            // Pulse outputs default low so each lasts exactly one cycle.
            done_reg       <= 1'b0;
            out_strobe_reg <= 1'b0;
            reg_we_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (STORE_Start) begin
                        busy_reg  <= 1'b1;
                        error_reg <= 1'b0;
                        case (STORE_OPCode)
                            2'b00: begin
                                out_port_reg   <= ACCUMULATOR;
                                out_strobe_reg <= 1'b1;
                                done_reg       <= 1'b1;
                                state_reg      <= ST_DONE;
                            end
                            2'b01: begin
                                reg_addr_reg  <= STORE_Addr[REG_ADDR_W-1:0];
                                reg_wdata_reg <= ACCUMULATOR;
                                reg_we_reg    <= 1'b1;
                                done_reg      <= 1'b1;
                                state_reg     <= ST_DONE;
                            end
                            2'b10: begin
                                ram_req_reg   <= 1'b1;
                                ram_addr_reg  <= STORE_Addr;
                                ram_wdata_reg <= ACCUMULATOR;
                                state_reg     <= ST_RAM_WAIT;
`ifdef ACCU_STORE_TIMEOUT_EN
                                wait_cnt_reg  <= CNT_W'(1);
`endif
                            end
                            default: begin
                                error_reg <= 1'b1;
                                done_reg  <= 1'b1;
                                state_reg <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_RAM_WAIT: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (RAM_Ack) begin
                        ram_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
`ifdef ACCU_STORE_TIMEOUT_EN
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
                        ram_req_reg <= 1'b0;
                        error_reg   <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign STORE_Busy  = busy_reg;
    assign STORE_Done  = done_reg;
    assign STORE_Error = error_reg;
    assign OUT_Port    = out_port_reg;
    assign OUT_Strobe  = out_strobe_reg;
    assign REG_WE      = reg_we_reg;
    assign REG_Addr    = reg_addr_reg;
    assign REG_WData   = reg_wdata_reg;
    assign RAM_Req     = ram_req_reg;
    assign RAM_WE      = ram_req_reg;
    assign RAM_Addr    = ram_addr_reg;
    assign RAM_WData   = ram_wdata_reg;

endmodule

// File: tb/tb_accu_store_unit.sv
// Scoreboard bench for accu_store_unit: driver pushes expected outcomes, monitor checks each Done.
module tb_accu_store_unit;

    localparam int TMO = 4;
`ifdef ACCU_STORE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CPU_Reset = 1'b1;
    logic       STORE_Start = 1'b0;
    logic [1:0] STORE_OPCode = 2'b00;
    logic [7:0] STORE_Addr = 8'h00;
    logic [7:0] ACCUMULATOR = 8'h00;
    logic       RAM_Ack = 1'b0;
    logic       STORE_Busy, STORE_Done, STORE_Error, OUT_Strobe, REG_WE, RAM_Req, RAM_WE;
    logic [7:0] OUT_Port, REG_WData, RAM_Addr, RAM_WData;
    logic [2:0] REG_Addr;

    accu_store_unit #(
        .DATA_W(8), .ADDR_W(8), .REG_ADDR_W(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .CPU_Reset(CPU_Reset), .STORE_Start(STORE_Start),
        .STORE_OPCode(STORE_OPCode), .STORE_Addr(STORE_Addr), .ACCUMULATOR(ACCUMULATOR),
        .STORE_Busy(STORE_Busy), .STORE_Done(STORE_Done), .STORE_Error(STORE_Error),
        .OUT_Port(OUT_Port), .OUT_Strobe(OUT_Strobe), .REG_WE(REG_WE), .REG_Addr(REG_Addr),
        .REG_WData(REG_WData), .RAM_Req(RAM_Req), .RAM_WE(RAM_WE), .RAM_Addr(RAM_Addr),
        .RAM_WData(RAM_WData), .RAM_Ack(RAM_Ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
        int         done_cyc;
        int         req_cycles;
        logic       written;
        logic [7:0] port_val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] model_out = 8'h00;
    logic       model_err = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: RAM request tracking and scoreboard pop on every Done pulse.
    int         req_cnt = 0;
    int         last_req = 0;
    logic       ack_seen = 1'b0;
    logic [7:0] cap_addr = 8'h00;
    logic [7:0] cap_data = 8'h00;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;

    always @(negedge CLK) begin
        if (CPU_Reset) begin
            req_cnt  = 0;
            last_req = 0;
            ack_seen = 1'b0;
        end else begin
            if (RAM_Req || RAM_WE) chk("ram_we_eq_req", RAM_WE, RAM_Req);
            if (RAM_Req) begin
                if (req_cnt == 0) begin
                    cap_addr = RAM_Addr;
                    cap_data = RAM_WData;
                end else begin
                    chk("ram_addr_stable", RAM_Addr, cap_addr);
                    chk("ram_data_stable", RAM_WData, cap_data);
                end
                req_cnt++;
                if (RAM_Ack) begin
                    ack_seen = 1'b1;
                    wr_addr  = RAM_Addr;
                    wr_data  = RAM_WData;
                end
            end else if (req_cnt > 0) begin
                last_req = req_cnt;
                req_cnt  = 0;
            end
            if ((OUT_Strobe || REG_WE) && !STORE_Done)
                chk("write_without_done", {OUT_Strobe, REG_WE}, 0);
            if (STORE_Done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("txn op=%0d addr=%02h data=%02h err=%0b cycle=%0d", e.op, e.addr, e.data, STORE_Error, cyc);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_at_done", STORE_Busy, 1);
                    chk("error", STORE_Error, e.err);
                    chk("out_port", OUT_Port, e.port_val);
                    chk("out_strobe", OUT_Strobe, e.op == 2'd0);
                    chk("reg_we", REG_WE, e.op == 2'd1);
                    if (e.op == 2'd1) begin
                        chk("reg_addr", REG_Addr, e.addr[2:0]);
                        chk("reg_wdata", REG_WData, e.data);
                    end
                    chk("req_cycles", last_req, e.req_cycles);
                    chk("ram_written", ack_seen, e.written);
                    if (e.written) begin
                        chk("ram_addr", wr_addr, e.addr);
                        chk("ram_wdata", wr_data, e.data);
                    end
                end
                last_req = 0;
                ack_seen = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (STORE_Busy && n < 30) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 30) chk("busy_timeout", STORE_Busy, 0);
    endtask

    // ack_k: RAM_Ack is raised in the ack_k-th request cycle (0 = never).
    task automatic do_store(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                            input int ack_k, input bit poke);
        exp_t e;
        int   e0;
        bit   timed_out;
        wait_idle();
        chk("sticky_error", STORE_Error, model_err);
        @(posedge CLK); #1;
        STORE_Start  = 1'b1;
        STORE_OPCode = op;
        STORE_Addr   = addr;
        ACCUMULATOR  = data;
        e0 = cyc + 1;
        timed_out = TMO_EN && (ack_k == 0 || ack_k > TMO);
        e.op = op; e.addr = addr; e.data = data;
        e.written = 1'b0; e.req_cycles = 0; e.done_cyc = e0; e.err = 1'b0;
        if (op == 2'd0) model_out = data;
        if (op == 2'd3) e.err = 1'b1;
        if (op == 2'd2) begin
            e.req_cycles = timed_out ? TMO : ack_k;
            e.done_cyc   = e0 + e.req_cycles;
            e.written    = !timed_out;
            e.err        = timed_out;
        end
        e.port_val = model_out;
        model_err  = e.err;
        q.push_back(e);
        @(posedge CLK); #1;
        STORE_Start  = 1'b0;
        ACCUMULATOR  = 8'($urandom);
        STORE_Addr   = 8'($urandom);
        STORE_OPCode = 2'($urandom);
        chk("busy_after_start", STORE_Busy, 1);
        chk("error_at_start", STORE_Error, op == 2'd3);
        if (op == 2'd2) begin
            for (int i = 1; i <= 40; i++) begin
                RAM_Ack     = (i == ack_k);
                STORE_Start = poke && (i == 2);
                @(posedge CLK); #1;
                STORE_Start = 1'b0;
                if (i == ack_k || (TMO_EN && i == TMO)) break;
            end
            RAM_Ack = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        CPU_Reset = 1'b0;
        chk("rst_busy", STORE_Busy, 0);
        chk("rst_done", STORE_Done, 0);
        chk("rst_error", STORE_Error, 0);
        chk("rst_out_port", OUT_Port, 0);
        chk("rst_strobe", OUT_Strobe, 0);
        chk("rst_reg_we", REG_WE, 0);
        chk("rst_ram_req", RAM_Req, 0);
        chk("rst_ram_we", RAM_WE, 0);

        do_store(2'd0, 8'h12, 8'hA5, 0, 0);
        repeat (10) @(posedge CLK);
        #1;
        chk("port_hold", OUT_Port, 8'hA5);

        do_store(2'd1, 8'h0D, 8'h3C, 0, 0);
        ACCUMULATOR = 8'h00;
        repeat (4) @(posedge CLK);
        #1;

        do_store(2'd2, 8'h40, 8'h77, 4, 1);
        do_store(2'd3, 8'h55, 8'h99, 0, 0);
        do_store(2'd0, 8'h01, 8'h5A, 0, 0);

        // Reset during the second RAM_WAIT cycle.
        wait_idle();
        @(posedge CLK); #1;
        STORE_Start = 1'b1; STORE_OPCode = 2'd2; STORE_Addr = 8'h80; ACCUMULATOR = 8'hC3;
        @(posedge CLK); #1;
        STORE_Start = 1'b0;
        @(posedge CLK); #1;
        CPU_Reset = 1'b1;
        @(posedge CLK); #1;
        CPU_Reset = 1'b0;
        model_out = 8'h00;
        model_err = 1'b0;
        chk("mid_rst_ram_req", RAM_Req, 0);
        chk("mid_rst_busy", STORE_Busy, 0);
        chk("mid_rst_out_port", OUT_Port, 0);
        RAM_Ack = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RAM_Ack = 1'b0;
        chk("stray_ack_busy", STORE_Busy, 0);
        chk("stray_ack_req", RAM_Req, 0);

        if (TMO_EN) begin
            do_store(2'd2, 8'h21, 8'hE1, 0, 0);
            do_store(2'd2, 8'h22, 8'hE2, TMO, 0);
        end

        for (int n = 0; n < 40; n++) begin
            do_store(2'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(1, TMO_EN ? 7 : 6)), bit'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge CLK);
        #1;
        chk("scoreboard_empty", q.size(), 0);
        chk("final_out_port", OUT_Port, model_out);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
